// File: rtl/hamming16_popcount.sv
`default_nettype none
// ============================================================================
// Module      : hamming16_popcount
// Description : Hamming weight of a 16-bit word. A balanced adder tree drives
//               the combinational count. A one-cycle registered copy has a
//               valid flag.
// Revision    : 1.0 - initial release
// ============================================================================
module hamming16_popcount (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] x,
    input  logic        in_valid,
    output logic [4:0]  count,
    output logic [4:0]  count_q,
    output logic        out_valid
);

    // Each tree level widens by one bit, so no partial sum can truncate.
    logic [1:0] w_l1 [8];
    logic [2:0] w_l2 [4];
    logic [3:0] w_l3 [2];
    logic [4:0] w_l4;

    logic [4:0] r_count_q;
    logic       r_out_valid;

    // Level 1: adjacent bit pairs give sums in the range 0..2.
    generate
        for (genvar i = 0; i < 8; i++) begin : g_level1
            assign w_l1[i] = {1'b0, x[2*i]} + {1'b0, x[2*i+1]};
        end
    endgenerate

    // Level 2: pairs of 2-bit sums give sums in the range 0..4.
    generate
        for (genvar i = 0; i < 4; i++) begin : g_level2
            assign w_l2[i] = {1'b0, w_l1[2*i]} + {1'b0, w_l1[2*i+1]};
        end
    endgenerate

    // Level 3: pairs of 3-bit sums give sums in the range 0..8.
    generate
        for (genvar i = 0; i < 2; i++) begin : g_level3
            assign w_l3[i] = {1'b0, w_l2[2*i]} + {1'b0, w_l2[2*i+1]};
        end
    endgenerate

    // Level 4: the root sum is in the range 0..16. It is independent of
    // clk, rst_n and in_valid.
    assign w_l4  = {1'b0, w_l3[0]} + {1'b0, w_l3[1]};
    assign count = w_l4;

    // Registered copy. Reset clears any pending result at once. count_q holds
    // its value whenever in_valid is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count_q   <= 5'd0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_count_q <= w_l4;
            end
        end
    end

    assign count_q   = r_count_q;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_hamming16_popcount.sv
`default_nettype none
// ============================================================================
// Module      : tb_hamming16_popcount
// Description : Directed and swept self-checking bench for hamming16_popcount
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hamming16_popcount;

    logic        clk;
    logic        rst_n;
    logic [15:0] x;
    logic        in_valid;
    logic [4:0]  count;
    logic [4:0]  count_q;
    logic        out_valid;

    int errors;
    int checks;

    hamming16_popcount dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .x         (x),
        .in_valid  (in_valid),
        .count     (count),
        .count_q   (count_q),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit-serial reference count
    function automatic logic [4:0] ref_pop(input logic [15:0] v);
        logic [4:0] n;
        n = 5'd0;
        for (int b = 0; b < 16; b++) begin
            n = n + {4'd0, v[b]};
        end
        return n;
    endfunction

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        x        = 16'hFFFF;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (count_q !== 5'd0) begin
            errors++;
            $display("FAIL reset_count_q actual=%0d expected=0", count_q);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid actual=%b expected=0", out_valid);
        end
        checks++;
        if (count !== 5'd16) begin
            errors++;
            $display("FAIL reset_comb_count actual=%0d expected=16", count);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_exhaustive();
        logic [4:0] exp;
        for (int v = 0; v < 65536; v++) begin
            x = v[15:0];
            #1;
            exp = ref_pop(x);
            checks++;
            if (count !== exp) begin
                errors++;
                $display("FAIL exhaustive x=%h actual=%0d expected=%0d", x, count, exp);
            end
        end
    endtask

    task automatic test_corners();
        logic [15:0] pats [8];
        logic [4:0]  exps [8];
        pats[0] = 16'h0000; exps[0] = 5'd0;
        pats[1] = 16'h0001; exps[1] = 5'd1;
        pats[2] = 16'h8000; exps[2] = 5'd1;
        pats[3] = 16'hFFFF; exps[3] = 5'd16;
        pats[4] = 16'hAAAA; exps[4] = 5'd8;
        pats[5] = 16'h5555; exps[5] = 5'd8;
        pats[6] = 16'h00FF; exps[6] = 5'd8;
        pats[7] = 16'h7FFF; exps[7] = 5'd15;
        for (int k = 0; k < 8; k++) begin
            x = pats[k];
            #1;
            checks++;
            if (count !== exps[k]) begin
                errors++;
                $display("FAIL corner x=%h actual=%0d expected=%0d", x, count, exps[k]);
            end
        end
    endtask

    task automatic test_latency();
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        x        = 16'h0F0F;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (count_q !== 5'd8 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL latency_capture count_q=%0d out_valid=%b expected 8/1", count_q, out_valid);
        end
        @(negedge clk);
        x        = 16'hFFFF;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (count_q !== 5'd8 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_hold count_q=%0d out_valid=%b expected 8/0", count_q, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] pats [3];
        logic [4:0]  exps [3];
        pats[0] = 16'h0000; exps[0] = 5'd0;
        pats[1] = 16'hFFFF; exps[1] = 5'd16;
        pats[2] = 16'h1234; exps[2] = 5'd5;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            x        = pats[k];
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            checks++;
            if (count_q !== exps[k] || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL back_to_back[%0d] count_q=%0d out_valid=%b expected %0d/1",
                         k, count_q, out_valid, exps[k]);
            end
        end
    endtask

    // Entered at posedge+1 with out_valid=1 from the stream test.
    task automatic test_async_reset();
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (count_q !== 5'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset count_q=%0d out_valid=%b expected 0/0", count_q, out_valid);
        end
        x = 16'h00FF;
        #1;
        checks++;
        if (count !== 5'd8) begin
            errors++;
            $display("FAIL async_reset_comb actual=%0d expected=8", count);
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_parity();
        logic [4:0] exp;
        for (int k = 0; k < 10000; k++) begin
            x = 16'($urandom);
            #1;
            exp = ref_pop(x);
            checks++;
            if (count[0] !== ^x || count !== exp) begin
                errors++;
                $display("FAIL parity x=%h actual=%0d expected=%0d parity=%b",
                         x, count, exp, ^x);
            end
        end
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        x        = 16'h0000;
        test_reset();
        test_exhaustive();
        test_corners();
        test_latency();
        test_back_to_back();
        test_async_reset();
        test_parity();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
